// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int          IFU_DEPTH     = 64;
  localparam int          IFU_ADDR_W    = 6;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] IFU_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] IFU_NOP_WORD  = 32'h0000_0000;

  // Fetch FSM: either stepping through memory or parked until a redirect.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: instruction handshake, redirect request and program load port.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6
);

  logic [31:0]       instr;
  logic [31:0]       pc_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halted;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;

  // The fetch unit drives instructions and status, everything else is input to it.
  modport master (
    output instr, pc_out, instr_valid, halted,
    input  instr_ready, redirect_valid, redirect_pc, load_en, load_addr, load_data
  );

  // Consumer / boot side.
  modport slave (
    input  instr, pc_out, instr_valid, halted,
    output instr_ready, redirect_valid, redirect_pc, load_en, load_addr, load_data
  );

endinterface

// File: rtl/instr_fetch_unit_imem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// A read of the word being written in the same cycle returns the old contents.
module instr_fetch_unit_imem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o
);

  logic [31:0] mem_q [DEPTH];

  // Program load write; contents are never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, output register and redirect handling.
// Optional feature macro: IFU_PERF_CNT_EN adds a saturating accepted-fetch counter (fetch_count_o).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          DEPTH     = IFU_DEPTH,
  parameter int          ADDR_W    = IFU_ADDR_W,
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter logic [31:0] HALT_WORD = IFU_HALT_WORD
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  instr_fetch_unit_if.master   bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_count_o
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [31:0] mem_word;
  logic        adv;
  logic        pc_in_range;
  logic        unused_redirect_lsbs;

  // The low two redirect bits are discarded: fetch addresses are word aligned.
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  instr_fetch_unit_imem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk_i     (clk_i),
    .wr_en_i   (bus.load_en),
    .wr_addr_i (bus.load_addr),
    .wr_data_i (bus.load_data),
    .rd_addr_i (pc_q[ADDR_W+1:2]),
    .rd_data_o (mem_word)
  );

  assign adv         = !valid_q || bus.instr_ready;
  assign pc_in_range = (pc_q[31:ADDR_W+2] == '0);

  // Next-state: redirect overrides everything, otherwise fetch when the output slot frees up.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    if (bus.redirect_valid) begin
      // Any instruction currently presented is dropped, even if accepted this cycle.
      pc_d     = {bus.redirect_pc[31:2], 2'b00};
      valid_d  = 1'b0;
      state_d  = ST_FETCH;
      halted_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (adv) begin
            if (!pc_in_range || mem_word == HALT_WORD) begin
              // The halt marker itself is never handed to the consumer.
              valid_d  = 1'b0;
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              instr_d  = mem_word;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + 32'd4;
            end
          end
        end
        ST_HALT: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; memory contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= IFU_NOP_WORD;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] count_q, count_d;

  // Count handshakes that actually deliver an instruction; a redirect cancels the delivery.
  always_comb begin
    count_d = count_q;
    if (valid_q && bus.instr_ready && !bus.redirect_valid && count_q != 32'hFFFF_FFFF) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count_o = count_q;
`endif

endmodule
